mem_port_arbiter: RTL

Two-requester arbiter that shares the single byte-addressable `DummyMemory` port between the instruction-fetch path (I) and the load/store path (D). Requests use valid/ready handshakes and are registered, then issued to memory. Responses return two cycles after acceptance with byte, half or word extraction and sign/zero extension. The block sits between the core's fetch and LSU stages and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_port_arbiter_load_extend.sv | 28 ++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the I/D memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    // Byte accesses are always aligned; anything not byte/half is a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MEM_SIZE_BYTE: return 1'b0;
            MEM_SIZE_HALF: return addr_lo[0];
            default:       return addr_lo != 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Byte/half/word extraction with sign or zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] result_o
);

    always_comb begin
        result_o = raw_i;
        case (size_i)
            MEM_SIZE_BYTE: result_o = {{(XLEN-8){~unsigned_i & raw_i[7]}}, raw_i[7:0]};
            MEM_SIZE_HALF: result_o = {{(XLEN-16){~unsigned_i & raw_i[15]}}, raw_i[15:0]};
            default:       result_o = raw_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one memory port between fetch (I)
//               and load/store (D). Optional alignment checking is enabled by
//               defining MEM_PORT_ARBITER_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            i_valid,
    output logic            i_ready,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    output logic            i_err,

    input  logic            d_valid,
    output logic            d_ready,
    input  logic [XLEN-1:0] d_addr,
    input  logic            d_we,
    input  logic [1:0]      d_size,
    input  logic            d_unsigned,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_err,

    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [1:0]      mem_write_size,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);

    arb_state_t      state_q;
    arb_port_t       last_grant_q;
    arb_port_t       owner_q;
    logic [XLEN-1:0] addr_q;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [XLEN-1:0] wdata_q;
    logic            err_q;

    logic            i_rvalid_q;
    logic [XLEN-1:0] i_rdata_q;
    logic            i_err_q;
    logic            d_rvalid_q;
    logic [XLEN-1:0] d_rdata_q;
    logic            d_err_q;

    arb_port_t       w_grant;
    logic            w_slot;
    logic            w_hs;
    logic            w_access;
    logic [XLEN-1:0] w_req_addr;
    logic [1:0]      w_req_size;
    logic            w_misaligned;
    logic [XLEN-1:0] w_ext;

    // Under contention the port that did not win last time takes the slot.
    always_comb begin
        w_grant = (last_grant_q == PORT_D) ? PORT_I : PORT_D;
        if (i_valid && !d_valid) begin
            w_grant = PORT_I;
        end else if (d_valid && !i_valid) begin
            w_grant = PORT_D;
        end
    end

    assign w_slot     = (state_q == IDLE) || (state_q == RESP);
    assign i_ready    = w_slot && i_valid && (w_grant == PORT_I);
    assign d_ready    = w_slot && d_valid && (w_grant == PORT_D);
    assign w_hs       = i_ready || d_ready;

    assign w_req_addr = (w_grant == PORT_I) ? i_addr : d_addr;
    assign w_req_size = (w_grant == PORT_I || d_size == 2'd3) ? MEM_SIZE_WORD : d_size;

`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(w_req_size, w_req_addr[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // Write enable also drops on reset so a store cut off by reset never commits.
    assign w_access       = (state_q == ACCESS);
    assign mem_addr       = w_access ? addr_q : '0;
    assign mem_we         = w_access && we_q && !err_q && !reset;
    assign mem_write_size = w_access ? size_q : MEM_SIZE_BYTE;
    assign mem_wd         = w_access ? wdata_q : '0;

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .raw_i      (mem_rd),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_D;
            owner_q      <= PORT_I;
            addr_q       <= '0;
            we_q         <= 1'b0;
            size_q       <= MEM_SIZE_BYTE;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            i_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            i_err_q      <= 1'b0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= '0;
            d_err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    i_rvalid_q <= 1'b0;
                    i_rdata_q  <= '0;
                    i_err_q    <= 1'b0;
                    d_rvalid_q <= 1'b0;
                    d_rdata_q  <= '0;
                    d_err_q    <= 1'b0;
                    if (w_hs) begin
                        state_q      <= ACCESS;
                        last_grant_q <= w_grant;
                        owner_q      <= w_grant;
                        addr_q       <= w_req_addr;
                        we_q         <= (w_grant == PORT_D) && d_we;
                        size_q       <= w_req_size;
                        uns_q        <= (w_grant == PORT_D) && d_unsigned;
                        wdata_q      <= (w_grant == PORT_D) ? d_wdata : '0;
                        err_q        <= w_misaligned;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    state_q    <= RESP;
                    i_rvalid_q <= (owner_q == PORT_I);
                    d_rvalid_q <= (owner_q == PORT_D);
                    i_rdata_q  <= (owner_q == PORT_I && !err_q) ? mem_rd : '0;
                    d_rdata_q  <= (owner_q == PORT_D && !we_q && !err_q) ? w_ext : '0;
                    i_err_q    <= (owner_q == PORT_I) && err_q;
                    d_err_q    <= (owner_q == PORT_D) && err_q;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign i_err    = i_err_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;

endmodule
`default_nettype wire
